pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the en/clear inputs of the four synchronous pipeline registers (PS1 IF/ID, PS2 ID/EX, PS3 EX/MEM, PS4 MEM/WB) and the PC enable.
- Decides load-use bubbles, taken-branch flushes, multi-cycle data-memory freezes, and the halt/restart sequence.
- Keeps stall and flush statistics counters.

Parameters:
- CNT_WIDTH, 32, width of the stall_cycles and flush_count counters.
- LOAD_USE_BUBBLE, 1, 1 = insert a bubble on a load-use hazard; 0 = never (for forwarding-to-MEM variants).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- regfile_req_a_id  input  5  rs of the instruction in ID
- regfile_req_b_id  input  5  rt of the instruction in ID
- regfile_req_w_ex  input  5  destination register of the instruction in EX (PS2 output)
- r_datamem_ex  input  1  instruction in EX is a load
- branch_taken_ex  input  1  taken branch/jump resolved in EX
- datamem_busy  input  1  data memory has not finished the access presented this cycle
- halt_wb  input  1  halt flag at PS4 output
- resume  input  1  single-cycle pulse that restarts after a halt
- pc_en  output  1  PC register load enable
- en_ps1, en_ps2, en_ps3, en_ps4  output  1 each  pipeline register enables
- clear_ps1, clear_ps2, clear_ps3, clear_ps4  output  1 each  pipeline register synchronous clears
- halted  output  1  core halted (state HALTED)
- stall_cycles  output  CNT_WIDTH  cycles lost to load-use or datamem_busy
- flush_count  output  CNT_WIDTH  number of taken-branch flush events

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low. On reset: state=RUN, stall_cycles=0, flush_count=0, halted=0.
- All en/clear/pc_en outputs are combinational decodes of state plus current inputs, so they act in the same cycle. Counters and state are registered.
- Load-use hazard: load_use = LOAD_USE_BUBBLE & r_datamem_ex & (regfile_req_w_ex != 0) & (regfile_req_w_ex == regfile_req_a_id | regfile_req_w_ex == regfile_req_b_id).
- FSM states: RUN, HALTED, RESTART.
- RUN decode, first match wins:
  1. halt_wb=1: pc_en=0, all en=0, all clear=0. Next state HALTED.
  2. datamem_busy=1: pc_en=0, all en=0, all clear=0 (full freeze). stall_cycles+1.
  3. branch_taken_ex=1: pc_en=1, all en=1, clear_ps1=1, clear_ps2=1, clear_ps3=clear_ps4=0. flush_count+1. Takes priority over load_use.
  4. load_use=1: pc_en=0, en_ps1=0, clear_ps2=1, en_ps3=en_ps4=1; clear_ps1, clear_ps3, clear_ps4 = 0. stall_cycles+1.
  5. Otherwise: pc_en=1, all en=1, all clear=0.
- HALTED:
  - pc_en=0, all en=0, all clear=0, halted=1.
  - Inputs other than resume and rst_n are ignored.
  - resume=1 -> next state RESTART.
- RESTART (exactly 1 cycle):
  - pc_en=0, all en=0, clear_ps1..clear_ps4=1. This drains the halt flag and any in-flight instructions.
  - halted=0. Next state RUN unconditionally.
- resume outside HALTED has no effect.
- Counters saturate at all-ones; they never wrap. They are not cleared by halt or restart, only by rst_n.
- Registers written on a clear cycle always receive zeros, regardless of the en value in that cycle.
- Reset asserted mid-freeze or mid-halt returns to RUN immediately. Counters and halted are zeroed asynchronously.

Test Plan:
1. Load-use bubble. In RUN: r_datamem_ex=1, regfile_req_w_ex=5, regfile_req_a_id=5, no other events.
   -> pc_en=0, en_ps1=0, clear_ps2=1, en_ps3=1, en_ps4=1; stall_cycles goes 0->1.
   Repeat with regfile_req_w_ex=0 and regfile_req_a_id=0 -> no stall.
2. Branch vs load-use priority. branch_taken_ex=1 together with the load_use condition.
   -> clear_ps1=1, clear_ps2=1, pc_en=1; flush_count=1; stall_cycles unchanged.
3. Memory freeze. datamem_busy=1 for 3 cycles while branch_taken_ex=1.
   -> all en=0 and pc_en=0 for 3 cycles, no clears; stall_cycles=3; flush_count increments only in the cycle busy drops.
4. Halt and restart. halt_wb=1 in RUN -> same-cycle full freeze, halted=1 next cycle.
   Hold 10 cycles with datamem_busy toggling -> outputs stay frozen, stall_cycles unchanged.
   Pulse resume -> 1 cycle with all clear=1, then normal RUN outputs.
5. Saturation. CNT_WIDTH=4, hold datamem_busy=1 for 20 cycles -> stall_cycles reaches 15 and stays at 15.
6. Asynchronous reset. rst_n low mid-HALTED, between clock edges -> halted=0 and counters=0 immediately; after release, RUN decode resumes.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for the 5-stage core. It drives the enable and
// synchronous-clear inputs of the four pipeline registers and the PC enable.
// It decides load-use bubbles, taken-branch flushes, data-memory freezes and
// the halt/restart sequence. It also keeps saturating stall and flush counters.
//
// Ports
//   clk, rst_n            core clock; asynchronous active-low reset
//   regfile_req_a_id/b_id source registers of the instruction in ID
//   regfile_req_w_ex      destination register of the instruction in EX
//   r_datamem_ex          instruction in EX is a load
//   branch_taken_ex       taken branch/jump resolved in EX
//   datamem_busy          data memory access not finished this cycle
//   halt_wb               halt flag at the PS4 output
//   resume                single-cycle restart pulse, honoured only while halted
//   pc_en                 PC load enable
//   en_ps1..en_ps4        pipeline register enables
//   clear_ps1..clear_ps4  pipeline register synchronous clears
//   halted                core is in the HALTED state
//   stall_cycles          cycles lost to load-use bubbles or memory freezes
//   flush_count           number of taken-branch flush events
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH       = 32,
    parameter bit          LOAD_USE_BUBBLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           regfile_req_a_id,
    input  logic [4:0]           regfile_req_b_id,
    input  logic [4:0]           regfile_req_w_ex,
    input  logic                 r_datamem_ex,
    input  logic                 branch_taken_ex,
    input  logic                 datamem_busy,
    input  logic                 halt_wb,
    input  logic                 resume,
    output logic                 pc_en,
    output logic                 en_ps1,
    output logic                 en_ps2,
    output logic                 en_ps3,
    output logic                 en_ps4,
    output logic                 clear_ps1,
    output logic                 clear_ps2,
    output logic                 clear_ps3,
    output logic                 clear_ps4,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        RESTART = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic load_use;
    logic stall_inc;
    logic flush_inc;

    // Register x0 is hard-wired to zero, so a load into x0 never creates a hazard.
    assign load_use = LOAD_USE_BUBBLE
                    & r_datamem_ex
                    & (regfile_req_w_ex != 5'd0)
                    & ((regfile_req_w_ex == regfile_req_a_id) |
                       (regfile_req_w_ex == regfile_req_b_id));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and same-cycle control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_en     = 1'b0;
        en_ps1    = 1'b0;
        en_ps2    = 1'b0;
        en_ps3    = 1'b0;
        en_ps4    = 1'b0;
        clear_ps1 = 1'b0;
        clear_ps2 = 1'b0;
        clear_ps3 = 1'b0;
        clear_ps4 = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        unique case (state)
            RUN: begin
                if (halt_wb) begin
                    // The halting instruction has retired. Freeze everything
                    // and wait for resume.
                    state_nxt = HALTED;
                end else if (datamem_busy) begin
                    // Full freeze. A pending branch is held in EX and flushes
                    // on the cycle the memory completes.
                    stall_inc = 1'b1;
                end else if (branch_taken_ex) begin
                    // Squash the two wrong-path instructions in IF/ID and
                    // ID/EX. This overrides any load-use bubble for them.
                    pc_en     = 1'b1;
                    en_ps1    = 1'b1;
                    en_ps2    = 1'b1;
                    en_ps3    = 1'b1;
                    en_ps4    = 1'b1;
                    clear_ps1 = 1'b1;
                    clear_ps2 = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, and insert a bubble into ID/EX. The
                    // enable stays high so the clear lands whatever the
                    // register's en/clear priority is.
                    en_ps2    = 1'b1;
                    en_ps3    = 1'b1;
                    en_ps4    = 1'b1;
                    clear_ps2 = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    pc_en  = 1'b1;
                    en_ps1 = 1'b1;
                    en_ps2 = 1'b1;
                    en_ps3 = 1'b1;
                    en_ps4 = 1'b1;
                end
            end

            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_nxt = RESTART;
                end
            end

            RESTART: begin
                // Drain the halt flag and every in-flight instruction.
                clear_ps1 = 1'b1;
                clear_ps2 = 1'b1;
                clear_ps3 = 1'b1;
                clear_ps4 = 1'b1;
                state_nxt = RUN;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Statistics counters. They saturate at all-ones and only rst_n clears them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_count <= '0;
        end else if (flush_inc && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    // Control vector order: {pc_en, en_ps1..4, clear_ps1..4}
    localparam logic [8:0] V_RUN  = 9'b1_1111_0000;
    localparam logic [8:0] V_FRZ  = 9'b0_0000_0000;
    localparam logic [8:0] V_BR   = 9'b1_1111_1100;
    localparam logic [8:0] V_LU   = 9'b0_0111_0100;
    localparam logic [8:0] V_RST  = 9'b0_0000_1111;
    localparam logic [8:0] M_ALL  = 9'b1_1111_1111;
    localparam logic [8:0] M_LU   = 9'b1_1011_1111;   // en_ps2 is don't-care while clear_ps2=1

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_a, req_b, req_w;
    logic        ld, br, busy, hw, res;

    logic        pc_en, en1, en2, en3, en4, cl1, cl2, cl3, cl4, halted;
    logic [31:0] stall_cycles, flush_count;

    logic        s_pc_en, s_en1, s_en2, s_en3, s_en4, s_cl1, s_cl2, s_cl3, s_cl4, s_halted;
    logic [3:0]  s_stall, s_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(32), .LOAD_USE_BUBBLE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .regfile_req_a_id(req_a), .regfile_req_b_id(req_b), .regfile_req_w_ex(req_w),
        .r_datamem_ex(ld), .branch_taken_ex(br), .datamem_busy(busy),
        .halt_wb(hw), .resume(res),
        .pc_en(pc_en), .en_ps1(en1), .en_ps2(en2), .en_ps3(en3), .en_ps4(en4),
        .clear_ps1(cl1), .clear_ps2(cl2), .clear_ps3(cl3), .clear_ps4(cl4),
        .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow-counter instance, driven in lockstep, for the saturation check
    pipeline_hazard_ctrl #(.CNT_WIDTH(4), .LOAD_USE_BUBBLE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .regfile_req_a_id(req_a), .regfile_req_b_id(req_b), .regfile_req_w_ex(req_w),
        .r_datamem_ex(ld), .branch_taken_ex(br), .datamem_busy(busy),
        .halt_wb(hw), .resume(res),
        .pc_en(s_pc_en), .en_ps1(s_en1), .en_ps2(s_en2), .en_ps3(s_en3), .en_ps4(s_en4),
        .clear_ps1(s_cl1), .clear_ps2(s_cl2), .clear_ps3(s_cl3), .clear_ps4(s_cl4),
        .halted(s_halted), .stall_cycles(s_stall), .flush_count(s_flush)
    );

    typedef struct {
        int          id;
        logic [8:0]  ctl;
        logic [8:0]  mask;
        int unsigned stall;
        int unsigned flush;
        logic        halted;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;
    bit   stim_done = 1'b0;

    // Drive one cycle of inputs just after the rising edge and queue the
    // response expected for that cycle, before the next edge.
    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] w, input logic l, input logic bt,
                        input logic bz, input logic h, input logic rs,
                        input logic [8:0] ctl, input logic [8:0] mask,
                        input int unsigned st, input int unsigned fl, input logic hl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; req_a = a; req_b = b; req_w = w;
        ld = l; br = bt; busy = bz; hw = h; res = rs;
        e.id = vec_id; e.ctl = ctl; e.mask = mask;
        e.stall = st; e.flush = fl; e.halted = hl;
        q.push_back(e);
        vec_id++;
    endtask

    task automatic idle(input logic [8:0] ctl, input int unsigned st, input int unsigned fl,
                        input logic hl);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, M_ALL, st, fl, hl);
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin : monitor
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {pc_en, en1, en2, en3, en4, cl1, cl2, cl3, cl4};
                n_cmp++;
                if ((got & e.mask) !== (e.ctl & e.mask)) begin
                    n_bad++;
                    $display("FAIL ctl[v%0d]: got %b required %b (mask %b)", e.id, got, e.ctl, e.mask);
                end
                n_cmp++;
                if (stall_cycles !== 32'(e.stall)) begin
                    n_bad++;
                    $display("FAIL stall_cycles[v%0d]: got %0d required %0d", e.id, stall_cycles, e.stall);
                end
                n_cmp++;
                if (flush_count !== 32'(e.flush)) begin
                    n_bad++;
                    $display("FAIL flush_count[v%0d]: got %0d required %0d", e.id, flush_count, e.flush);
                end
                n_cmp++;
                if (halted !== e.halted) begin
                    n_bad++;
                    $display("FAIL halted[v%0d]: got %b required %b", e.id, halted, e.halted);
                end
                n_cmp++;
                if (s_stall !== 4'((e.stall > 15) ? 15 : e.stall)) begin
                    n_bad++;
                    $display("FAIL sat_stall[v%0d]: got %0d required %0d", e.id, s_stall,
                             (e.stall > 15) ? 15 : e.stall);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; req_a = '0; req_b = '0; req_w = '0;
        ld = 1'b0; br = 1'b0; busy = 1'b0; hw = 1'b0; res = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then release
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, M_ALL, 0, 0, 1'b0);
        idle(V_RUN, 0, 0, 1'b0);

        // 1. Load-use bubble (rs match, x0 load, rt match, non-load)
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU,  M_LU,  0, 0, 1'b0);
        idle(V_RUN, 1, 0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, M_ALL, 1, 0, 1'b0);
        step(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU,  M_LU,  1, 0, 1'b0);
        step(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, M_ALL, 2, 0, 1'b0);

        // 2. Branch beats load-use
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_BR,  M_ALL, 2, 0, 1'b0);
        idle(V_RUN, 2, 1, 1'b0);

        // 3. Memory freeze holding a taken branch for 3 cycles
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, V_FRZ, M_ALL, 2 + i, 1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR,  M_ALL, 5, 1, 1'b0);
        idle(V_RUN, 5, 2, 1'b0);

        // resume outside HALTED is ignored
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V_RUN, M_ALL, 5, 2, 1'b0);
        idle(V_RUN, 5, 2, 1'b0);

        // 4. Halt, hold 10 cycles with noise, then resume/restart
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ, M_ALL, 5, 2, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'(i % 2), 1'b1, 1'b0, V_FRZ, M_ALL, 5, 2, 1'b1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V_FRZ, M_ALL, 5, 2, 1'b1);
        idle(V_RST, 5, 2, 1'b0);
        idle(V_RUN, 5, 2, 1'b0);

        // 5. 20-cycle freeze: wide counter counts on, narrow one sticks at 15
        for (int i = 0; i < 20; i++)
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_FRZ, M_ALL, 5 + i, 2, 1'b0);
        idle(V_RUN, 25, 2, 1'b0);

        // 6. Asynchronous reset while halted, asserted between edges
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ, M_ALL, 25, 2, 1'b0);
        idle(V_FRZ, 25, 2, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, M_ALL, 0, 0, 1'b0);
        idle(V_RUN, 0, 0, 1'b0);
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU,  M_LU,  0, 0, 1'b0);
        idle(V_RUN, 1, 0, 1'b0);

        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
